// File: rtl/chnl_slave_node.sv
// Per-channel show-ahead ingress FIFO; head word, ID and length are visible the cycle after a push or pop.
// Accepts a word when enabled and not full; raises req only once a whole packet is buffered.
module chnl_slave_node #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          slv_en_i,
  input  logic [7:0]    slv_id_i,
  input  logic [2:0]    len_cfg_i,
  input  logic          chnl_vld_i,
  input  logic [31:0]   chnl_data_i,
  output logic          chnl_rdy_o,
  input  logic          fetch_i,
  output logic [31:0]   data_o,
  output logic [7:0]    id_o,
  output logic [7:0]    len_o,
  output logic          req_o,
  output logic [AW:0]   margin_o
);

  typedef enum logic {IDLE, IN_PKT} state_t;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [5:0]    r_pop_cnt;
  logic [5:0]    w_pop_cnt_nxt;
  logic [5:0]    r_len_q;
  logic [5:0]    w_len_q_nxt;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [5:0]    w_pkt_words;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = chnl_vld_i && chnl_rdy_o;
  assign w_pop   = fetch_i && !w_empty;

  always_comb begin
    w_pkt_words = 6'd32;
    case (len_cfg_i)
      3'd0:    w_pkt_words = 6'd4;
      3'd1:    w_pkt_words = 6'd8;
      3'd2:    w_pkt_words = 6'd16;
      default: w_pkt_words = 6'd32;
    endcase
  end

  assign chnl_rdy_o = slv_en_i && !w_full;
  assign data_o     = w_empty ? 32'h0 : r_mem[r_rd_ptr];
  assign id_o       = slv_id_i;
  assign margin_o   = (AW+1)'(DEPTH) - r_count;

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= chnl_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_pop_cnt <= '0;
      r_len_q   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pop_cnt <= w_pop_cnt_nxt;
      r_len_q   <= w_len_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pop_cnt_nxt = r_pop_cnt;
    w_len_q_nxt   = r_len_q;
    req_o         = 1'b0;
    len_o         = 8'(w_pkt_words) - 8'd1;
    case (r_state)
      IDLE: begin
        req_o = slv_en_i && (int'(r_count) >= int'(w_pkt_words));
        // An out-of-step pop still opens a packet so the formatter stays aligned.
        if (w_pop) begin
          w_state_nxt   = IN_PKT;
          w_pop_cnt_nxt = 6'd1;
          w_len_q_nxt   = w_pkt_words;
        end
      end
      IN_PKT: begin
        req_o = !w_empty;
        len_o = 8'(r_len_q) - 8'd1;
        if (w_pop) begin
          if (r_pop_cnt + 6'd1 == r_len_q) begin
            w_state_nxt   = IDLE;
            w_pop_cnt_nxt = 6'd0;
          end else begin
            w_pop_cnt_nxt = r_pop_cnt + 6'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/chnl_slave_node.md
# chnl_slave_node

Per-channel ingress buffer feeding one slot of the packet formatter. Accepts 32-bit words from a channel over a valid/ready handshake, stores them in a show-ahead FIFO, and presents head data, channel ID and packet length to the formatter together with a request that is raised only when a whole packet is available. Four instances sit directly upstream of the formatter, one per slave slot (slv0..slv3).

## Interface
- DEPTH, 32: FIFO depth in words; power of two, 8..256.
- AW, $clog2(DEPTH): pointer width.
- clk_i  input  1  clock; all logic on the rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- slv_en_i  input  1  channel enable from the register block.
- slv_id_i  input  8  channel ID; passed through to id_o.
- len_cfg_i  input  3  packet length code: 0→4, 1→8, 2→16, 3..7→32 words.
- chnl_vld_i  input  1  upstream word valid.
- chnl_data_i  input  32  upstream word.
- chnl_rdy_o  output  1  upstream ready; equals slv_en_i && !full.
- fetch_i  input  1  formatter pops head word (one bit of fetch_vec).
- data_o  output  32  FIFO head word; 0 when empty.
- id_o  output  8  equals slv_id_i.
- len_o  output  8  payload words minus one (3/7/15/31).
- req_o  output  1  packet available (one bit of req_vec).
- margin_o  output  AW+1  free slots, DEPTH − count, for register readback.

## Operation
- Storage: DEPTH×32 memory, write pointer, read pointer, count (AW+1 bits). Pointers wrap modulo DEPTH. Memory is not reset.
- Push: chnl_vld_i && chnl_rdy_o → write at wr_ptr, wr_ptr+1, count+1.
- Pop: fetch_i && !empty → rd_ptr+1, count−1. fetch_i while empty is ignored (the formatter may assert fetch when req_o is low); no pointer or count change.
- Simultaneous push and pop: both performed, count unchanged. When full, chnl_rdy_o is 0 regardless of a same-cycle pop; no push occurs that cycle.
- pkt_words = decoded length (4/8/16/32). Latched into len_q at the first pop of a packet.
- State IDLE / IN_PKT, plus pop counter pop_cnt (6 bits):
  - IDLE: req_o = slv_en_i && count ≥ pkt_words (from live len_cfg_i); len_o = pkt_words−1 from live config. First valid pop → IN_PKT, len_q latched, pop_cnt = 1.
  - IN_PKT: req_o = !empty (slv_en_i ignored); len_o = len_q−1. Each valid pop increments pop_cnt; the pop that makes pop_cnt = len_q → IDLE, pop_cnt = 0.
- A pop while IDLE with req_o low (formatter out of step) still enters IN_PKT; no error flag.
- slv_en_i deassert: blocks new pushes and new packet starts; an in-progress packet completes normally.
- len_cfg_i change during IN_PKT has no effect until IDLE.

## Timing
- Reset values: count 0, pointers 0, IDLE, pop_cnt 0; chnl_rdy_o = slv_en_i, req_o 0, data_o 0, margin_o DEPTH, len_o from len_cfg_i, id_o = slv_id_i.
- All outputs are combinational from registered state plus static config inputs; no combinational path from chnl_vld_i or fetch_i to any output.
- Push at edge k: word visible on data_o (if it became head), count/margin_o/req_o updated after edge k.
- Pop at edge k: next word on data_o after edge k; formatter samples data_o in the fetch cycle.
- Back-to-back pops every cycle sustain one word per cycle; back-to-back pushes sustain one word per cycle until full.
- Asynchronous reset mid-packet: all state cleared immediately; buffered words discarded.

## Test plan
- Reset, en=1, len_cfg=0: push 0xA0..0xA2 → req_o stays 0; push 0xA3 → req_o=1 next cycle, len_o=3, data_o=0xA0, margin_o=28.
- Continue: fetch 4 consecutive cycles → data_o 0xA0,0xA1,0xA2,0xA3; req_o stays 1 through the packet, drops to 0 after 4th pop, count 0, data_o 0.
- Push 32 words without fetch → chnl_rdy_o=0, margin_o=0; hold chnl_vld_i and fetch one cycle → count 31, no push that cycle; next cycle push accepted, count 32.
- Fetch while empty for 3 cycles → pointers, count, state unchanged; subsequent 4-word packet delivered intact.
- len_cfg=1, 8 words buffered, 2 popped, switch len_cfg=0 → len_o stays 7, packet ends after 8 pops; then len_o=3.
- Mid-packet slv_en_i=0 → chnl_rdy_o=0, packet completes, req_o=0 after; assert rst_n_i=0 mid-packet → all outputs at reset values immediately.
